instr_fetch_decode: RTL and testbench

- Front-end stage directly upstream of the calculator datapath.
- Holds the PC and fetches one 32-bit instruction word per request from instruction memory over a req/ack handshake.
- Splits the word into opcode/fonteA/dest/imediato fields.
- Presents the fields to the datapath/CONTROLE with a valid/ready handshake.
- Stops fetching permanently after delivering HCT (halt) until reset.

---
 rtl/instr_fetch_decode.sv | 131 +++++++++++++
 tb/tb_instr_fetch_decode.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - PC, one-outstanding fetch and field decode ahead of the datapath.
// Build option INSTR_COUNT_EN adds the accepted-instruction counter behind instr_count.
module instr_fetch_decode #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [2:0]  HALT_OPCODE = 3'b101
) (
  input  logic        _clock,
  input  logic        _reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  opcode,
  output logic [1:0]  fonteA,
  output logic [1:0]  dest,
  output logic [31:0] imediato,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {FETCH, DISCARD, VALID, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] ir_q;
  logic [31:0] pc_out_q;
  logic        mem_req_q;
  logic        out_valid_q;
  logic        halted_q;
  logic [31:0] pc_next_d;
  logic        accept_d;

  assign pc_next_d = pc_out_q + 32'd1;
  assign accept_d  = (state_q == VALID) && out_ready && !redirect_en;

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      ir_q        <= 32'd0;
      pc_out_q    <= 32'd0;
      mem_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!mem_req_q) begin
            // Nothing issued yet after reset: start the request, ignore stray acks.
            mem_req_q <= 1'b1;
            if (redirect_en) begin
              pc_q   <= redirect_pc;
              addr_q <= redirect_pc;
            end
          end else if (redirect_en) begin
            pc_q <= redirect_pc;
            if (mem_ack) addr_q <= redirect_pc;
            else         state_q <= DISCARD;
          end else if (mem_ack) begin
            ir_q        <= mem_data;
            pc_out_q    <= pc_q;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= VALID;
          end
        end
        DISCARD: begin
          // Old request stays on the bus until its ack; its data is dropped.
          if (redirect_en) pc_q <= redirect_pc;
          if (mem_ack) begin
            addr_q  <= redirect_en ? redirect_pc : pc_q;
            state_q <= FETCH;
          end
        end
        VALID: begin
          if (redirect_en) begin
            pc_q        <= redirect_pc;
            addr_q      <= redirect_pc;
            out_valid_q <= 1'b0;
            mem_req_q   <= 1'b1;
            state_q     <= FETCH;
          end else if (accept_d) begin
            out_valid_q <= 1'b0;
            if (ir_q[31:29] == HALT_OPCODE) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              pc_q      <= pc_next_d;
              addr_q    <= pc_next_d;
              mem_req_q <= 1'b1;
              state_q   <= FETCH;
            end
          end
        end
        HALT: begin
        end
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset)        count_q <= 32'd0;
    else if (accept_d) count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'd0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_addr  = addr_q;
  assign out_valid = out_valid_q;
  assign opcode    = ir_q[31:29];
  assign fonteA    = ir_q[28:27];
  assign dest      = ir_q[26:25];
  assign imediato  = {{7{ir_q[24]}}, ir_q[24:0]};
  assign pc_out    = pc_out_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - randomized bench with a program-order reference model for instr_fetch_decode.
module tb_instr_fetch_decode;

  localparam logic [2:0] HCT = 3'b101;

  logic        _clock = 1'b0;
  logic        _reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  opcode;
  logic [1:0]  fonteA;
  logic [1:0]  dest;
  logic [31:0] imediato;
  logic [31:0] pc_out;
  logic        halted;
  logic [31:0] instr_count;

  instr_fetch_decode dut (
    ._clock      (_clock),
    ._reset      (_reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode      (opcode),
    .fonteA      (fonteA),
    .dest        (dest),
    .imediato    (imediato),
    .pc_out      (pc_out),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 _clock = ~_clock;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] halt_addr = 32'h8000_0000;

  // Program-order model: the PC the next delivered instruction must carry.
  logic [31:0] exp_pc, stale_addr, m_count;
  logic        m_halted, stale, e_valid, e_req;
  int          req_cycles, lat, idle;
  bit          rand_lat;
  logic        r_ready, r_redir;
  logic [31:0] r_rpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'd0) return 32'h2A00_0005;
    if (a == 32'd1) return 32'h01FF_FFFF;
    if (a == halt_addr) return 32'hA000_0000;
    h = a * 32'h9E37_79B1 + 32'h7F4A_7C15;
    h = h ^ (h >> 15);
    if (h[31:29] == HCT) h[31:29] = 3'b100;
    return h;
  endfunction

  task automatic reset_model();
    exp_pc = 32'd0; m_count = 32'd0; m_halted = 1'b0; stale = 1'b0;
    e_valid = 1'b0; e_req = 1'b0; req_cycles = 0;
  endtask

  // Called at a falling edge: check outputs, drive inputs, predict next cycle.
  task automatic step();
    logic        ack;
    logic [31:0] w;
    w = word_at(exp_pc);
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("mem_req", 32'(mem_req), 32'(e_req));
    check("halted", 32'(halted), 32'(m_halted));
`ifdef INSTR_COUNT_EN
    check("instr_count", instr_count, m_count);
`else
    check("instr_count", instr_count, 32'd0);
`endif
    if (mem_req) begin
      if (stale) check("addr_hold", mem_addr, stale_addr);
      else       check("mem_addr", mem_addr, exp_pc);
    end
    if (out_valid) begin
      check("pc_out", pc_out, exp_pc);
      check("opcode", 32'(opcode), 32'(w[31:29]));
      check("fonteA", 32'(fonteA), 32'(w[28:27]));
      check("dest", 32'(dest), 32'(w[26:25]));
      check("imediato", imediato, {{7{w[24]}}, w[24:0]});
    end

    ack = mem_req && (req_cycles >= lat);
    if (mem_req) req_cycles = ack ? 0 : req_cycles + 1;
    if (ack && rand_lat) lat = $urandom_range(0, 3);
    mem_ack     = ack;
    mem_data    = ack ? word_at(mem_addr) : $urandom;
    out_ready   = r_ready;
    redirect_en = r_redir;
    redirect_pc = r_rpc;

    if (m_halted) begin
      e_valid = 1'b0; e_req = 1'b0;
    end else if (r_redir) begin
      if (mem_req && !ack && !stale) stale_addr = exp_pc;
      stale   = mem_req && !ack;
      exp_pc  = r_rpc;
      e_valid = 1'b0; e_req = 1'b1;
    end else if (out_valid) begin
      if (r_ready) begin
        m_count = m_count + 32'd1;
        e_valid = 1'b0;
        if (w[31:29] == HCT) begin
          m_halted = 1'b1; e_req = 1'b0;
        end else begin
          exp_pc = exp_pc + 32'd1; e_req = 1'b1;
        end
      end else begin
        e_valid = 1'b1; e_req = 1'b0;
      end
    end else if (mem_req && ack) begin
      e_valid = !stale; e_req = stale; stale = 1'b0;
    end else begin
      e_valid = 1'b0; e_req = 1'b1;
    end

    @(posedge _clock);
    @(negedge _clock);
  endtask

  task automatic run_until_valid(input int max_cycles);
    for (int i = 0; i < max_cycles && !out_valid; i++) step();
    check("wait_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    _reset = 1'b1; mem_ack = 1'b0; mem_data = 32'd0; out_ready = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'd0;
    r_ready = 1'b1; r_redir = 1'b0; r_rpc = 32'd0; lat = 2; rand_lat = 0;
    reset_model();
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_imediato", imediato, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    repeat (2) @(negedge _clock);
    _reset = 1'b0;

    // Basic fetch, memory latency 2
    run_until_valid(20);
    check("basic_opcode", 32'(opcode), 32'd1);
    check("basic_fonteA", 32'(fonteA), 32'd1);
    check("basic_dest", 32'(dest), 32'd1);
    check("basic_imm", imediato, 32'd5);
    check("basic_pc", pc_out, 32'd0);
    step();
    check("basic_next_req", 32'(mem_req), 32'd1);
    check("basic_next_addr", mem_addr, 32'd1);

    // Sign extension then back-pressure
    r_ready = 1'b0;
    run_until_valid(20);
    check("sext_imm", imediato, 32'hFFFF_FFFF);
    check("sext_opcode", 32'(opcode), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_req", 32'(mem_req), 32'd0);
      check("bp_imm", imediato, 32'hFFFF_FFFF);
    end
    r_ready = 1'b1;
    step();
    check("bp_resume_req", 32'(mem_req), 32'd1);
    check("bp_resume_addr", mem_addr, 32'd2);

    // Redirect while address 4 is outstanding
    r_ready = 1'b0; r_redir = 1'b1; r_rpc = 32'd4;
    step();
    r_redir = 1'b0;
    for (int i = 0; i < 20 && !(mem_req && !stale && mem_addr == 32'd4); i++) step();
    check("redir_at4", mem_addr, 32'd4);
    r_redir = 1'b1; r_rpc = 32'h40;
    step();
    r_redir = 1'b0;
    run_until_valid(20);
    check("redir_pc", pc_out, 32'h40);

    // PC wrap
    r_redir = 1'b1; r_rpc = 32'hFFFF_FFFF;
    step();
    r_redir = 1'b0;
    run_until_valid(20);
    check("wrap_pc", pc_out, 32'hFFFF_FFFF);
    r_ready = 1'b1;
    step();
    check("wrap_addr", mem_addr, 32'd0);

    // Random traffic
    rand_lat = 1; idle = 0;
    for (int i = 0; i < 400; i++) begin
      r_ready = ($urandom_range(0, 2) != 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 255));
      step();
      idle = out_valid ? 0 : idle + 1;
      if (idle > 60) begin
        check("stall", 32'(out_valid), 32'd1);
        idle = 0;
      end
    end
    r_redir = 1'b0;

    // Reset while an instruction is presented
    rand_lat = 0; lat = 1; r_ready = 1'b0;
    run_until_valid(20);
    _reset = 1'b1; mem_ack = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_pc_out", pc_out, 32'd0);
    check("mid_rst_count", instr_count, 32'd0);
    @(negedge _clock);
    _reset = 1'b0;
    reset_model();

    // Halt
    r_redir = 1'b1; r_rpc = halt_addr;
    step();
    r_redir = 1'b0;
    run_until_valid(20);
    check("halt_opcode", 32'(opcode), 32'(HCT));
    r_ready = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      r_redir = 1'($urandom_range(0, 1));
      r_rpc   = $urandom;
      step();
      check("halt_req", 32'(mem_req), 32'd0);
      check("halt_flag", 32'(halted), 32'd1);
    end
`ifdef INSTR_COUNT_EN
    check("halt_count", instr_count, 32'd1);
`else
    check("halt_count", instr_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
